mdc8p_ctrl_in: RTL and testbench

Input-side sequencer for the 8-point MDC FFT pipeline. It accepts a serial AXI-Stream of complex samples and double-buffers them into ping-pong 8-sample frames. Each full frame is then issued to the two-lane MDC datapath as four pairs (x[k], x[k+4]), k = 0..3, as the first radix-2 DIF stage requires. Frame issue is gated by a frame-level permit from the output side, so frames never overlap inside the pipeline.

---
 rtl/mdc8p_pkg.sv | 12 +
 rtl/mdc8p_pingpong_buf.sv | 36 +++
 rtl/mdc8p_ctrl_in.sv | 171 +++++++++++++++++
 tb/tb_mdc8p_ctrl_in.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdc8p_pkg.sv
// Shared constants and read-FSM encoding for the 8-point MDC FFT input sequencer.
package mdc8p_pkg;
  localparam int N_POINT = 8;
  localparam int N_HALF  = 4;
  localparam int WCNT_W  = 3;
  localparam int RCNT_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rd_state_t;
endpackage

// File: rtl/mdc8p_pingpong_buf.sv
// Two banks of 8 complex words: one write port, two combinational read ports
// returning x[k] and x[k+4] of the selected bank. Contents are never reset.
module mdc8p_pingpong_buf
  import mdc8p_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [WCNT_W-1:0] wr_addr,
  input  logic [2*NB-1:0]   wr_data,
  input  logic              rd_bank,
  input  logic [RCNT_W-1:0] rd_addr,
  output logic [2*NB-1:0]   rd_data0,
  output logic [2*NB-1:0]   rd_data1
);
  logic [2*NB-1:0] bank_rd0 [2];
  logic [2*NB-1:0] bank_rd1 [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [2*NB-1:0] mem [N_POINT];

    always_ff @(posedge i_clk) begin
      if (wr_en && (wr_bank == 1'(gi))) begin
        mem[wr_addr] <= wr_data;
      end
    end

    assign bank_rd0[gi] = mem[{1'b0, rd_addr}];
    assign bank_rd1[gi] = mem[{1'b1, rd_addr}];
  end

  assign rd_data0 = bank_rd0[rd_bank];
  assign rd_data1 = bank_rd1[rd_bank];
endmodule

// File: rtl/mdc8p_ctrl_in.sv
// Ping-pong input sequencer feeding (x[k], x[k+4]) pairs to the MDC datapath.
// Optional tlast framing check is enabled by defining MDC8P_TLAST_CHECK_EN.
module mdc8p_ctrl_in
  import mdc8p_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [2*NB-1:0] s_axis_data_tdata,
  input  logic            s_axis_data_tvalid,
  output logic            s_axis_data_tready,
  input  logic            s_axis_data_tlast,
  input  logic            i_fft_ready,
  output logic [NB-1:0]   o_data0_r,
  output logic [NB-1:0]   o_data0_i,
  output logic [NB-1:0]   o_data1_r,
  output logic [NB-1:0]   o_data1_i,
  output logic            o_valid,
  output logic            o_frame_start,
  output logic            o_busy,
  output logic            o_err_framing
);
  rd_state_t         state_reg, state_next;
  logic [1:0]        full_reg, full_next;
  logic              wbank_reg, wbank_next;
  logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
  logic              rbank_reg, rbank_next;
  logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
  logic              accept, commit, release_bank, issue, first_pair;
  logic [2*NB-1:0]   rd_data0, rd_data1;
`ifdef MDC8P_TLAST_CHECK_EN
  logic              tlast_err;
`endif

  assign s_axis_data_tready = !full_reg[wbank_reg];
  assign accept = s_axis_data_tvalid && s_axis_data_tready;
  assign o_busy = full_reg[0] | full_reg[1] | (state_reg == ST_RUN);

  mdc8p_pingpong_buf #(.NB(NB)) u_buf (
    .i_clk    (i_clk),
    .wr_en    (accept),
    .wr_bank  (wbank_reg),
    .wr_addr  (wcnt_reg),
    .wr_data  (s_axis_data_tdata),
    .rd_bank  (rbank_reg),
    .rd_addr  (rcnt_reg),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  always_comb begin
    wcnt_next  = wcnt_reg;
    wbank_next = wbank_reg;
    commit     = 1'b0;
`ifdef MDC8P_TLAST_CHECK_EN
    tlast_err  = 1'b0;
`endif
    if (accept) begin
      if (wcnt_reg == WCNT_W'(N_POINT - 1)) begin
        commit     = 1'b1;
        wbank_next = ~wbank_reg;
        wcnt_next  = '0;
`ifdef MDC8P_TLAST_CHECK_EN
        tlast_err  = !s_axis_data_tlast;
`endif
      end
`ifdef MDC8P_TLAST_CHECK_EN
      // Early tlast: drop the partial frame, the bank flag was never set.
      else if (s_axis_data_tlast) begin
        wcnt_next = '0;
        tlast_err = 1'b1;
      end
`endif
      else begin
        wcnt_next = wcnt_reg + 1'b1;
      end
    end
  end

  // Writer only sets flags of empty banks, reader only clears full ones.
  always_comb begin
    full_next = full_reg;
    if (commit)       full_next[wbank_reg] = 1'b1;
    if (release_bank) full_next[rbank_reg] = 1'b0;
  end

  always_comb begin
    state_next   = state_reg;
    rcnt_next    = rcnt_reg;
    rbank_next   = rbank_reg;
    release_bank = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (full_reg[rbank_reg] && i_fft_ready) begin
          state_next = ST_RUN;
          rcnt_next  = RCNT_W'(1);
        end
      end
      ST_RUN: begin
        rcnt_next = rcnt_reg + 1'b1;
        if (rcnt_reg == RCNT_W'(N_HALF - 1)) begin
          release_bank = 1'b1;
          rbank_next   = ~rbank_reg;
          // Stay in RUN with rcnt wrapping to 0 to chain the next frame.
          if (!(full_reg[~rbank_reg] && i_fft_ready)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    first_pair = 1'b0;
    case (state_reg)
      ST_IDLE: issue = full_reg[rbank_reg] && i_fft_ready;
      ST_RUN:  issue = 1'b1;
      default: issue = 1'b0;
    endcase
    first_pair = issue && (rcnt_reg == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      full_reg      <= '0;
      wbank_reg     <= 1'b0;
      wcnt_reg      <= '0;
      rbank_reg     <= 1'b0;
      rcnt_reg      <= '0;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
      o_data0_r     <= '0;
      o_data0_i     <= '0;
      o_data1_r     <= '0;
      o_data1_i     <= '0;
    end else begin
      state_reg     <= state_next;
      full_reg      <= full_next;
      wbank_reg     <= wbank_next;
      wcnt_reg      <= wcnt_next;
      rbank_reg     <= rbank_next;
      rcnt_reg      <= rcnt_next;
      o_valid       <= issue;
      o_frame_start <= first_pair;
      if (issue) begin
        o_data0_r <= rd_data0[2*NB-1:NB];
        o_data0_i <= rd_data0[NB-1:0];
        o_data1_r <= rd_data1[2*NB-1:NB];
        o_data1_i <= rd_data1[NB-1:0];
      end
    end
  end

`ifdef MDC8P_TLAST_CHECK_EN
  logic err_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_reg <= 1'b0;
    else          err_reg <= tlast_err;
  end

  assign o_err_framing = err_reg;
`else
  logic unused_tlast;

  assign unused_tlast  = s_axis_data_tlast;
  assign o_err_framing = 1'b0;
`endif
endmodule

// File: tb/tb_mdc8p_ctrl_in.sv
// Directed bench for mdc8p_ctrl_in: vector table for the basic frame, then
// hand sequences for streaming, back-pressure, tlast framing and async reset.
module tb_mdc8p_ctrl_in;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic        fft_ready = 1'b0;
  logic [7:0]  d0r, d0i, d1r, d1i;
  logic        o_valid, o_frame_start, o_busy, o_err_framing;

  int checks = 0;
  int errors = 0;

  mdc8p_ctrl_in #(.NB(8)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .s_axis_data_tdata  (tdata),
    .s_axis_data_tvalid (tvalid),
    .s_axis_data_tready (tready),
    .s_axis_data_tlast  (tlast),
    .i_fft_ready        (fft_ready),
    .o_data0_r          (d0r),
    .o_data0_i          (d0i),
    .o_data1_r          (d1r),
    .o_data1_i          (d1i),
    .o_valid            (o_valid),
    .o_frame_start      (o_frame_start),
    .o_busy             (o_busy),
    .o_err_framing      (o_err_framing)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        fs;
    logic [15:0] d0;
    logic [15:0] d1;
    int          stamp;
  } pair_t;

  pair_t pq[$];
  int    cyc = 0;
  int    err_pulses = 0;

  always @(posedge i_clk) begin
    cyc++;
    #1;
    if (o_valid) pq.push_back('{o_frame_start, {d0r, d0i}, {d1r, d1i}, cyc});
    if (o_err_framing) err_pulses++;
  end

  function automatic logic [15:0] word(input logic [7:0] n);
    return {n, 8'(8'd0 - n)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [7:0] n, input logic last, output logic rdy);
    @(negedge i_clk);
    tvalid = v;
    tdata  = word(n);
    tlast  = last;
    rdy    = tready;
    @(posedge i_clk);
  endtask

  task automatic idle(input int ncyc, output logic rdy);
    for (int i = 0; i < ncyc; i++) beat(1'b0, 8'd0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pq.delete();
    err_pulses = 0;
  endtask

  typedef struct {
    logic        tvalid;
    logic [7:0]  n;
    logic        rdy;
    logic        valid;
    logic        fs;
    logic        busy;
    logic [15:0] d0;
    logic [15:0] d1;
  } vec_t;

  vec_t tv[13];

  initial begin
    logic rdy;
    int   notrdy;
    int   f, k;
    logic [7:0] e0[4];
    logic [7:0] e1[4];
    int   exp_err;

    // Frame of n=0..7 (real=n, imag=-n): pairs appear 1..4 clocks after the 8th beat.
    tv[0]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[1]  = '{1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[2]  = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[3]  = '{1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[4]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[5]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[6]  = '{1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[7]  = '{1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tv[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h04FC};
    tv[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h01FF, 16'h05FB};
    tv[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h02FE, 16'h06FA};
    tv[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h03FD, 16'h07F9};
    tv[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_tready", 32'(tready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_frame_start", 32'(o_frame_start), 32'd0);
    chk("rst_err", 32'(o_err_framing), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'({d0r, d0i, d1r, d1i}), 32'd0);
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    fft_ready = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge i_clk);
      tvalid = tv[i].tvalid;
      tdata  = word(tv[i].n);
      tlast  = tv[i].tvalid && (tv[i].n == 8'd7);
      chk($sformatf("tbl%0d_tready", i), 32'(tready), 32'(tv[i].rdy));
      @(posedge i_clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tv[i].valid));
      chk($sformatf("tbl%0d_fs", i), 32'(o_frame_start), 32'(tv[i].fs));
      chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tv[i].busy));
      if (tv[i].valid) begin
        chk($sformatf("tbl%0d_d0", i), 32'({d0r, d0i}), 32'(tv[i].d0));
        chk($sformatf("tbl%0d_d1", i), 32'({d1r, d1i}), 32'(tv[i].d1));
      end
    end

    // Four frames back to back: tready never drops, 4 pairs then a 4-cycle gap.
    do_reset();
    fft_ready = 1'b1;
    notrdy = 0;
    for (int fi = 0; fi < 4; fi++) begin
      for (int i = 0; i < 8; i++) begin
        beat(1'b1, 8'(fi * 8 + i), i == 7, rdy);
        if (!rdy) notrdy++;
      end
    end
    idle(8, rdy);
    chk("cont_tready_low_cycles", 32'(notrdy), 32'd0);
    chk("cont_pair_count", 32'(pq.size()), 32'd16);
    for (int j = 0; j < pq.size() && j < 16; j++) begin
      f = j / 4;
      k = j % 4;
      chk($sformatf("cont%0d_d0", j), 32'(pq[j].d0), 32'(word(8'(f * 8 + k))));
      chk($sformatf("cont%0d_d1", j), 32'(pq[j].d1), 32'(word(8'(f * 8 + k + 4))));
      chk($sformatf("cont%0d_fs", j), 32'(pq[j].fs), 32'(k == 0));
      chk($sformatf("cont%0d_slot", j), 32'(pq[j].stamp - pq[0].stamp), 32'(f * 8 + k));
    end

    // Back-pressure: both banks fill, tready drops, then two frames back to back.
    do_reset();
    fft_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, 8'(i), (i % 8) == 7, rdy);
      chk($sformatf("bp_tready_%0d", i), 32'(rdy), 32'(i < 16));
    end
    #1;
    chk("bp_busy_full", 32'(o_busy), 32'd1);
    chk("bp_no_output", 32'(pq.size()), 32'd0);
    fft_ready = 1'b1;
    idle(10, rdy);
    #1;
    chk("bp_pair_count", 32'(pq.size()), 32'd8);
    for (int j = 0; j < pq.size() && j < 8; j++) begin
      f = j / 4;
      k = j % 4;
      chk($sformatf("bp%0d_d0", j), 32'(pq[j].d0), 32'(word(8'(f * 8 + k))));
      chk($sformatf("bp%0d_d1", j), 32'(pq[j].d1), 32'(word(8'(f * 8 + k + 4))));
      chk($sformatf("bp%0d_fs", j), 32'(pq[j].fs), 32'(k == 0));
      chk($sformatf("bp%0d_slot", j), 32'(pq[j].stamp - pq[0].stamp), 32'(j));
    end
    chk("bp_tready_after", 32'(tready), 32'd1);
    chk("bp_busy_after", 32'(o_busy), 32'd0);

    // tlast on the 5th beat, then an 8-beat frame.
`ifdef MDC8P_TLAST_CHECK_EN
    e0 = '{8'd100, 8'd101, 8'd102, 8'd103};
    e1 = '{8'd104, 8'd105, 8'd106, 8'd107};
    exp_err = 1;
`else
    e0 = '{8'd0, 8'd1, 8'd2, 8'd3};
    e1 = '{8'd4, 8'd100, 8'd101, 8'd102};
    exp_err = 0;
`endif
    do_reset();
    fft_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(1'b1, 8'(i), i == 4, rdy);
    for (int i = 0; i < 8; i++) beat(1'b1, 8'(100 + i), i == 7, rdy);
    idle(8, rdy);
    chk("tlast_err_pulses", 32'(err_pulses), 32'(exp_err));
    chk("tlast_pair_count", 32'(pq.size()), 32'd4);
    for (int j = 0; j < pq.size() && j < 4; j++) begin
      chk($sformatf("tlast%0d_d0", j), 32'(pq[j].d0), 32'(word(e0[j])));
      chk($sformatf("tlast%0d_d1", j), 32'(pq[j].d1), 32'(word(e1[j])));
      chk($sformatf("tlast%0d_fs", j), 32'(pq[j].fs), 32'(j == 0));
    end

    // Async reset while pair 2 is on the lanes.
    do_reset();
    fft_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(1'b1, 8'(20 + i), i == 7, rdy);
    idle(3, rdy);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_pairs_before", 32'(pq.size()), 32'd3);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_tready", 32'(tready), 32'd1);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_data", 32'({d0r, d0i, d1r, d1i}), 32'd0);
    pq.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) beat(1'b1, 8'(50 + i), i == 7, rdy);
    idle(8, rdy);
    chk("arst_pair_count", 32'(pq.size()), 32'd4);
    for (int j = 0; j < pq.size() && j < 4; j++) begin
      chk($sformatf("arst%0d_d0", j), 32'(pq[j].d0), 32'(word(8'(50 + j))));
      chk($sformatf("arst%0d_d1", j), 32'(pq[j].d1), 32'(word(8'(54 + j))));
      chk($sformatf("arst%0d_fs", j), 32'(pq[j].fs), 32'(j == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
